// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared widths, header layout and entry type for the router
//               output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   localparam int DATA_W      = 8;
   localparam int HDR_LEN_LSB = 2;
   localparam int HDR_ADDR_W  = 2;

   // One stored FIFO entry: header flag above the data byte.
   typedef struct packed {
      logic              lfd;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

   // Pointer width: one extra MSB distinguishes full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : Read/write pointers, accepted-request qualification, occupancy
//               count and empty/full/almost_full flags for the router FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
   import router_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   localparam int PW       = ptr_w(DEPTH),
   localparam int AW       = PW - 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          soft_reset,
   input  logic          write_enb,
   input  logic          read_enb,
   output logic          wr_ok,
   output logic          rd_ok,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [PW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          almost_full
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;

   // Flags and request qualification from registered state; a flush wins.
   always_comb begin
      empty       = (wr_ptr_q == rd_ptr_q);
      full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      almost_full = (count_q >= PW'(AF_THRESH));
      wr_ok       = write_enb && !full  && !soft_reset;
      rd_ok       = read_enb  && !empty && !soft_reset;
      wr_addr     = wr_ptr_q[AW-1:0];
      rd_addr     = rd_ptr_q[AW-1:0];
      count       = count_q;
   end

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (soft_reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_fifo
// Description : Router output-channel FIFO. Stores bytes with a header flag,
//               registers read data, and tracks packet boundaries with a
//               read-side counter loaded from the header length field.
//               Optional build macro ROUTER_FIFO_ERR_FLAGS_EN adds sticky
//               overflow/underflow error outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_fifo
   import router_pkg::*;
#(
   parameter int DATA_W    = router_pkg::DATA_W,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       soft_reset,
   input  logic                       write_enb,
   input  logic                       read_enb,
   input  logic                       lfd_state,
   input  logic [DATA_W-1:0]          data_in,
   output logic [DATA_W-1:0]          data_out,
   output logic                       data_out_valid,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [ptr_w(DEPTH)-1:0]    count,
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
   output logic                       ovf_err,
   output logic                       udf_err,
`endif
   output logic                       pkt_busy
);

   localparam int AW    = ptr_w(DEPTH) - 1;
   localparam int PKT_W = DATA_W - 1;
   localparam int LEN_W = DATA_W - HDR_LEN_LSB;

   typedef struct packed {
      logic              lfd;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic          wr_ok, rd_ok;
   logic [AW-1:0] wr_addr, rd_addr;
   entry_t        mem_q [DEPTH];
   entry_t        rd_entry;
   logic [LEN_W-1:0] hdr_len;

   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_q, valid_d;
   logic [PKT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

   fifo_ptr_ctrl #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
   ) u_ptr_ctrl (
      .clk         (clk),
      .resetn      (resetn),
      .soft_reset  (soft_reset),
      .write_enb   (write_enb),
      .read_enb    (read_enb),
      .wr_ok       (wr_ok),
      .rd_ok       (rd_ok),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full)
   );

   // Storage array; contents are don't-care after reset so it is not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_addr] <= '{lfd: lfd_state, data: data_in};
   end

   // Read data, valid strobe and packet counter next-state.
   always_comb begin
      rd_entry   = mem_q[rd_addr];
      hdr_len    = rd_entry.data[DATA_W-1:HDR_LEN_LSB];
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      pkt_cnt_d  = pkt_cnt_q;
      if (soft_reset) begin
         data_out_d = '0;
         pkt_cnt_d  = '0;
      end else if (rd_ok) begin
         data_out_d = rd_entry.data;
         valid_d    = 1'b1;
         if (rd_entry.lfd)
            pkt_cnt_d = PKT_W'(hdr_len) + PKT_W'(1);
         else if (pkt_cnt_q != '0)
            pkt_cnt_d = pkt_cnt_q - PKT_W'(1);
      end
   end

   // Read-side registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_out_q <= '0;
         valid_q    <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign data_out       = data_out_q;
   assign data_out_valid = valid_q;
   assign pkt_busy       = (pkt_cnt_q != '0);

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
   logic ovf_err_q, ovf_err_d;
   logic udf_err_q, udf_err_d;

   // Sticky illegal-request flags; only a reset or flush clears them.
   always_comb begin
      ovf_err_d = ovf_err_q | (write_enb & full);
      udf_err_d = udf_err_q | (read_enb & empty);
      if (soft_reset) begin
         ovf_err_d = 1'b0;
         udf_err_d = 1'b0;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_err_q <= 1'b0;
         udf_err_q <= 1'b0;
      end else begin
         ovf_err_q <= ovf_err_d;
         udf_err_q <= udf_err_d;
      end
   end

   assign ovf_err = ovf_err_q;
   assign udf_err = udf_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_fifo
// Description : Directed self-checking bench for router_pkt_fifo
//               (DATA_W=8, DEPTH=16, AF_THRESH=14).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_fifo;

   logic       clk = 1'b0;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       empty, full, almost_full, pkt_busy;
   logic [4:0] count;
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
   logic       ovf_err, udf_err;
`endif

   int passed = 0;
   int total  = 0;

   // Reference model: queue of stored bytes and expected read register.
   logic [7:0] q[$];
   logic [7:0] exp_dout = 8'h00;
   logic       exp_valid = 1'b0;

   router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .soft_reset     (soft_reset),
      .write_enb      (write_enb),
      .read_enb       (read_enb),
      .lfd_state      (lfd_state),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .empty          (empty),
      .full           (full),
      .almost_full    (almost_full),
      .count          (count),
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
      .ovf_err        (ovf_err),
      .udf_err        (udf_err),
`endif
      .pkt_busy       (pkt_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock with the given requests; model updated on pre-edge state.
   task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] d);
      bit rd_acc, wr_acc;
      write_enb = we;
      read_enb  = re;
      lfd_state = lfd;
      data_in   = d;
      rd_acc = re && (q.size() > 0);
      wr_acc = we && (q.size() < 16);
      @(posedge clk);
      #1;
      exp_valid = rd_acc;
      if (rd_acc) exp_dout = q.pop_front();
      if (wr_acc) q.push_back(d);
      write_enb = 1'b0;
      read_enb  = 1'b0;
      lfd_state = 1'b0;
   endtask

   logic [7:0] pkt [5];

   initial begin
      pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hB2; pkt[3] = 8'hC3; pkt[4] = 8'h5E;
      resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
      lfd_state = 1'b0; data_in = 8'h00;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // Reset state
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_count", count, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_valid", data_out_valid, 0);
      chk("rst_busy", pkt_busy, 0);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
      chk("rst_ovf", ovf_err, 0);
      chk("rst_udf", udf_err, 0);
`endif

      // Asynchronous reset in the middle of a write sequence
      cyc(1, 0, 1, 8'h0D);
      cyc(1, 0, 0, 8'hA1);
      cyc(1, 1, 0, 8'hB2);
      chk("pre_arst_count", count, 2);
      chk("pre_arst_dout", data_out, 8'h0D);
      write_enb = 1'b1; data_in = 8'hC3;
      #2 resetn = 1'b0;
      #1;
      chk("arst_empty", empty, 1);
      chk("arst_count", count, 0);
      chk("arst_dout", data_out, 0);
      chk("arst_busy", pkt_busy, 0);
      @(posedge clk);
      #1 resetn = 1'b1; write_enb = 1'b0;
      q.delete(); exp_dout = 8'h00;

      // Packet: header len=3 addr=1, three payload bytes, parity
      for (int i = 0; i < 5; i++) cyc(1, 0, (i == 0), pkt[i]);
      chk("pkt_count", count, 5);
      cyc(0, 1, 0, 8'h00);
      chk("pkt_dout0", data_out, 8'h0D);
      chk("pkt_valid0", data_out_valid, 1);
      chk("pkt_cnt_hdr", dut.pkt_cnt_q, 4);
      chk("pkt_busy_hdr", pkt_busy, 1);
      for (int i = 1; i < 5; i++) begin
         cyc(0, 1, 0, 8'h00);
         chk("pkt_dout", data_out, pkt[i]);
         chk("pkt_cnt", dut.pkt_cnt_q, 4 - i);
         chk("pkt_busy", pkt_busy, (i < 4));
      end
      cyc(0, 0, 0, 8'h00);
      chk("pkt_hold_dout", data_out, 8'h5E);
      chk("pkt_idle_valid", data_out_valid, 0);
      chk("pkt_empty", empty, 1);

      // Fill to full, almost_full threshold, dropped writes
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, 8'h10 + 8'(i));
         if (i == 12) chk("af_at13", almost_full, 0);
         if (i == 13) chk("af_at14", almost_full, 1);
         if (i == 14) chk("notfull_at15", full, 0);
      end
      chk("full_flag", full, 1);
      chk("full_count", count, 16);
      cyc(1, 0, 0, 8'hFF);
      chk("full_drop_count", count, 16);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
      chk("ovf_set", ovf_err, 1);
`endif
      cyc(1, 1, 0, 8'hEE);
      chk("full_rw_count", count, 15);
      chk("full_rw_dout", data_out, 8'h10);
      chk("full_rw_full", full, 0);
      for (int i = 1; i < 16; i++) begin
         cyc(0, 1, 0, 8'h00);
         chk("full_rd", data_out, 8'h10 + 8'(i));
      end
      chk("full_drain_empty", empty, 1);
      chk("full_drain_busy", pkt_busy, 0);

      // Simultaneous read/write at count 5
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'h30 + 8'(i));
      for (int i = 0; i < 10; i++) begin
         cyc(1, 1, 0, 8'h40 + 8'(i));
         chk("rw5_count", count, 5);
         chk("rw5_dout", data_out, exp_dout);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, 8'h00);
         chk("rw5_drain", data_out, 8'h45 + 8'(i));
      end

      // Continuous traffic across pointer wrap
      cyc(1, 0, 0, 8'h77);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 1, 0, 8'($urandom_range(0, 255)));
         chk("wrap_dout", data_out, exp_dout);
         chk("wrap_valid", data_out_valid, exp_valid);
         chk("wrap_empty", empty, 0);
         chk("wrap_count", count, q.size());
      end
      cyc(0, 1, 0, 8'h00);
      chk("wrap_last", data_out, exp_dout);
      chk("wrap_end_empty", empty, 1);

      // Flush after 3 of 5 packet bytes read
      for (int i = 0; i < 5; i++) cyc(1, 0, (i == 0), pkt[i]);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00);
      chk("sr_pre_dout", data_out, 8'hB2);
      chk("sr_pre_busy", pkt_busy, 1);
      soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h99;
      @(posedge clk);
      #1 soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
      q.delete(); exp_dout = 8'h00;
      chk("sr_empty", empty, 1);
      chk("sr_count", count, 0);
      chk("sr_busy", pkt_busy, 0);
      chk("sr_dout", data_out, 0);
      chk("sr_valid", data_out_valid, 0);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
      chk("sr_ovf_clr", ovf_err, 0);
      cyc(0, 1, 0, 8'h00);
      chk("udf_set", udf_err, 1);
      chk("udf_valid", data_out_valid, 0);
      cyc(1, 0, 0, 8'h12);
      cyc(0, 1, 0, 8'h00);
      chk("udf_sticky", udf_err, 1);
      chk("udf_rd", data_out, 8'h12);
      soft_reset = 1'b1;
      @(posedge clk);
      #1 soft_reset = 1'b0;
      chk("udf_clr", udf_err, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
